// File: rtl/vram_pkg.sv
// Shared widths and fill-engine state encoding for the VRAM access arbiter slice.
package vram_pkg;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 16;
    localparam int VRAM_WORDS = 8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;
endpackage

// File: rtl/vram_fill_engine.sv
// Fill engine: walks an address range writing one pattern word per grant it receives.
module vram_fill_engine
    import vram_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fill_start,
    input  logic              i_fill_abort,
    input  logic [ADDR_W-1:0] i_fill_base,
    input  logic [ADDR_W:0]   i_fill_len,
    input  logic [DATA_W-1:0] i_fill_pattern,
    input  logic              i_fill_grant,
    output logic              o_fill_want,
    output logic [ADDR_W-1:0] o_fill_addr,
    output logic [DATA_W-1:0] o_fill_pattern,
    output logic              o_fill_busy,
    output logic              o_fill_done
);
    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic              w_accept;
    logic              w_zero_len;
    logic              r_zero_done;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [DATA_W-1:0] r_pattern;

    // Next-state decode; an abort wins over reaching the last word so no done pulse follows it.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_zero_len  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_fill_start && (|i_fill_len)) begin
                    w_state_nxt = FILL;
                    w_accept    = 1'b1;
                end else if (i_fill_start) begin
                    w_zero_len  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                if (i_fill_abort) begin
                    w_state_nxt = IDLE;
                end else if (i_fill_grant && (r_remaining == {{ADDR_W{1'b0}}, 1'b1})) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, range counters and latched pattern.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_zero_done <= 1'b0;
            r_cur_addr  <= {ADDR_W{1'b0}};
            r_remaining <= {(ADDR_W+1){1'b0}};
            r_pattern   <= {DATA_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_zero_done <= w_zero_len;
            if (w_accept) begin
                r_cur_addr  <= i_fill_base;
                r_remaining <= i_fill_len;
                r_pattern   <= i_fill_pattern;
            end else if ((r_state == FILL) && i_fill_grant) begin
                r_cur_addr  <= r_cur_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                r_remaining <= r_remaining - {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    assign o_fill_want    = (r_state == FILL);
    assign o_fill_addr    = r_cur_addr;
    assign o_fill_pattern = r_pattern;
    assign o_fill_busy    = (r_state == FILL);
    assign o_fill_done    = (r_state == DONE) | r_zero_done;
endmodule

// File: rtl/vram_access_arbiter.sv
// Shares the Screen VRAM port between the CPU (priority) and the fill engine,
// forcing one fill slot after FILL_SLOT consecutive contested CPU grants.
module vram_access_arbiter
    import vram_pkg::*;
#(
    parameter int FILL_SLOT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ready,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_fill_start,
    input  logic              i_fill_abort,
    input  logic [ADDR_W-1:0] i_fill_base,
    input  logic [ADDR_W:0]   i_fill_len,
    input  logic [DATA_W-1:0] i_fill_pattern,
    output logic              o_fill_busy,
    output logic              o_fill_done,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [DATA_W-1:0] o_vram_din,
    output logic              o_vram_load,
    input  logic [DATA_W-1:0] i_vram_dout
);
    localparam int CNT_W = $clog2(FILL_SLOT + 1);

    logic              w_fill_want;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_pattern;
    logic              w_contest;
    logic              w_slot_due;
    logic              w_cpu_grant;
    logic              w_fill_grant;
    logic [CNT_W-1:0]  r_slot_cnt;
    logic              r_rd_pend;
    logic              r_rvalid;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [DATA_W-1:0] r_vram_din;
    logic              r_vram_load;

    vram_fill_engine u_fill (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_fill_start   (i_fill_start),
        .i_fill_abort   (i_fill_abort),
        .i_fill_base    (i_fill_base),
        .i_fill_len     (i_fill_len),
        .i_fill_pattern (i_fill_pattern),
        .i_fill_grant   (w_fill_grant),
        .o_fill_want    (w_fill_want),
        .o_fill_addr    (w_fill_addr),
        .o_fill_pattern (w_fill_pattern),
        .o_fill_busy    (o_fill_busy),
        .o_fill_done    (o_fill_done)
    );

    assign w_contest    = i_cpu_req & w_fill_want;
    assign w_slot_due   = w_contest & (r_slot_cnt == CNT_W'(FILL_SLOT));
    assign w_cpu_grant  = i_cpu_req & ~w_slot_due;
    assign w_fill_grant = w_fill_want & (~i_cpu_req | w_slot_due);

    // Contest counter: counts consecutive contested CPU wins, cleared by the fill slot or no contest.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_cnt <= {CNT_W{1'b0}};
        end else if (w_contest && !w_slot_due) begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        end else begin
            r_slot_cnt <= {CNT_W{1'b0}};
        end
    end

    // Registered VRAM port plus the two-stage read-valid pipeline matching Screen's output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vram_addr <= {ADDR_W{1'b0}};
            r_vram_din  <= {DATA_W{1'b0}};
            r_vram_load <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            r_rd_pend <= w_cpu_grant & ~i_cpu_we;
            r_rvalid  <= r_rd_pend;
            if (w_cpu_grant) begin
                r_vram_addr <= i_cpu_addr;
                r_vram_din  <= i_cpu_wdata;
                r_vram_load <= i_cpu_we;
            end else if (w_fill_grant) begin
                r_vram_addr <= w_fill_addr;
                r_vram_din  <= w_fill_pattern;
                r_vram_load <= 1'b1;
            end else begin
                r_vram_load <= 1'b0;
            end
        end
    end

    // Read data is only presented while it is valid.
    always_comb begin
        o_cpu_rdata = {DATA_W{1'b0}};
        if (r_rvalid) begin
            o_cpu_rdata = i_vram_dout;
        end else begin
            o_cpu_rdata = {DATA_W{1'b0}};
        end
    end

    assign o_cpu_ready  = w_cpu_grant;
    assign o_cpu_rvalid = r_rvalid;
    assign o_vram_addr  = r_vram_addr;
    assign o_vram_din   = r_vram_din;
    assign o_vram_load  = r_vram_load;
endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a registered-output Screen model.
module tb_vram_access_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cpu_req, i_cpu_we;
    logic [12:0] i_cpu_addr;
    logic [15:0] i_cpu_wdata;
    logic        o_cpu_ready, o_cpu_rvalid;
    logic [15:0] o_cpu_rdata;
    logic        i_fill_start, i_fill_abort;
    logic [12:0] i_fill_base;
    logic [13:0] i_fill_len;
    logic [15:0] i_fill_pattern;
    logic        o_fill_busy, o_fill_done;
    logic [12:0] o_vram_addr;
    logic [15:0] o_vram_din;
    logic        o_vram_load;
    logic [15:0] r_dout;

    logic [15:0] mem    [0:8191];
    int          wr_cnt [0:8191];
    int          snap   [0:8191];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 i_clk = ~i_clk;

    vram_access_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .o_cpu_ready(o_cpu_ready),
        .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata),
        .i_fill_start(i_fill_start), .i_fill_abort(i_fill_abort),
        .i_fill_base(i_fill_base), .i_fill_len(i_fill_len), .i_fill_pattern(i_fill_pattern),
        .o_fill_busy(o_fill_busy), .o_fill_done(o_fill_done),
        .o_vram_addr(o_vram_addr), .o_vram_din(o_vram_din), .o_vram_load(o_vram_load),
        .i_vram_dout(r_dout)
    );

    // Screen model: synchronous write, registered read of the presented address.
    always @(posedge i_clk) begin
        if (o_vram_load) begin
            mem[o_vram_addr]    <= o_vram_din;
            wr_cnt[o_vram_addr] <= wr_cnt[o_vram_addr] + 1;
        end
        r_dout <= mem[o_vram_addr];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic take_snap();
        for (int a = 0; a < 8192; a++) snap[a] = wr_cnt[a];
    endtask

    task automatic start_fill(input logic [12:0] base, input logic [13:0] len, input logic [15:0] pat);
        i_fill_start = 1'b1; i_fill_base = base; i_fill_len = len; i_fill_pattern = pat;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 13'd0; i_cpu_wdata = 16'd0;
        i_fill_start = 1'b0; i_fill_abort = 1'b0; i_fill_base = 13'd0; i_fill_len = 14'd0;
        i_fill_pattern = 16'd0;
        tick(); tick();
        n_cmp++; if ({o_cpu_ready, o_cpu_rvalid, o_fill_busy, o_fill_done, o_vram_load} !== 5'b0) begin
            $display("FAIL reset_flags: got %b want 00000", {o_cpu_ready, o_cpu_rvalid, o_fill_busy, o_fill_done, o_vram_load}); n_fail++; end
        n_cmp++; if ({o_vram_addr, o_vram_din, o_cpu_rdata} !== 45'd0) begin
            $display("FAIL reset_buses: addr %h din %h rdata %h want 0", o_vram_addr, o_vram_din, o_cpu_rdata); n_fail++; end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_rw();
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 13'h0005; i_cpu_wdata = 16'h1234;
        #1;
        n_cmp++; if (o_cpu_ready !== 1'b1) begin $display("FAIL wr_ready: got %b want 1", o_cpu_ready); n_fail++; end
        tick();
        i_cpu_we = 1'b0;
        #1;
        n_cmp++; if ({o_vram_load, o_vram_addr, o_vram_din} !== {1'b1, 13'h0005, 16'h1234}) begin
            $display("FAIL wr_port: load %b addr %h din %h want 1 0005 1234", o_vram_load, o_vram_addr, o_vram_din); n_fail++; end
        tick();
        i_cpu_req = 1'b0;
        #1;
        n_cmp++; if ({o_vram_load, o_vram_addr, o_cpu_rvalid} !== {1'b0, 13'h0005, 1'b0}) begin
            $display("FAIL rd_port: load %b addr %h rvalid %b want 0 0005 0", o_vram_load, o_vram_addr, o_cpu_rvalid); n_fail++; end
        tick();
        n_cmp++; if ({o_cpu_rvalid, o_cpu_rdata} !== {1'b1, 16'h1234}) begin
            $display("FAIL rd_data: rvalid %b rdata %h want 1 1234", o_cpu_rvalid, o_cpu_rdata); n_fail++; end
        tick();
        n_cmp++; if (o_cpu_rvalid !== 1'b0) begin $display("FAIL rd_single: rvalid %b want 0", o_cpu_rvalid); n_fail++; end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'hA001; vals[1] = 16'hA002; vals[2] = 16'hA003;
        for (int i = 0; i < 3; i++) begin
            i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 13'h0010 + 13'(i); i_cpu_wdata = vals[i];
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            i_cpu_req = (i < 3); i_cpu_we = 1'b0; i_cpu_addr = 13'h0010 + 13'(i);
            #1;
            n_cmp++; if (o_cpu_rvalid !== (i >= 2 && i <= 4)) begin
                $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, o_cpu_rvalid, (i >= 2 && i <= 4)); n_fail++; end
            if (i >= 2 && i <= 4) begin
                n_cmp++; if (o_cpu_rdata !== vals[i-2]) begin
                    $display("FAIL b2b_rdata[%0d]: got %h want %h", i, o_cpu_rdata, vals[i-2]); n_fail++; end
            end
            tick();
        end
        i_cpu_req = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [12:0] exp_a [4];
        exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF; exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
        take_snap();
        start_fill(13'h1FFE, 14'd4, 16'hAAAA);
        tick();
        i_fill_start = 1'b0;
        n_cmp++; if (o_fill_busy !== 1'b1) begin $display("FAIL wrap_busy: got %b want 1", o_fill_busy); n_fail++; end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if ({o_vram_load, o_vram_addr, o_vram_din} !== {1'b1, exp_a[k], 16'hAAAA}) begin
                $display("FAIL wrap_word[%0d]: load %b addr %h din %h want 1 %h aaaa", k, o_vram_load, o_vram_addr, o_vram_din, exp_a[k]); n_fail++; end
        end
        n_cmp++; if ({o_fill_done, o_fill_busy} !== 2'b10) begin
            $display("FAIL wrap_done: done,busy %b want 10", {o_fill_done, o_fill_busy}); n_fail++; end
        tick();
        n_cmp++; if ({o_fill_done, o_vram_load} !== 2'b00) begin
            $display("FAIL wrap_after: done,load %b want 00", {o_fill_done, o_vram_load}); n_fail++; end
        n_cmp++; if ((wr_cnt[13'h1FFD] - snap[13'h1FFD]) + (wr_cnt[2] - snap[2]) !== 0) begin
            $display("FAIL wrap_neighbours: extra writes %0d want 0", (wr_cnt[13'h1FFD] - snap[13'h1FFD]) + (wr_cnt[2] - snap[2])); n_fail++; end
    endtask

    task automatic test_contention();
        int  bad;
        logic got;
        start_fill(13'h0100, 14'd10, 16'h00F0);
        tick();
        i_fill_start = 1'b0;
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 13'h0200; i_cpu_wdata = 16'h1111;
        for (int i = 0; i < 15; i++) begin
            #1;
            n_cmp++; if (o_cpu_ready !== ((i % 5) != 4)) begin
                $display("FAIL slot_ready[%0d]: got %b want %b", i, o_cpu_ready, ((i % 5) != 4)); n_fail++; end
            if (i == 5) begin
                n_cmp++; if ({o_vram_load, o_vram_addr, o_vram_din} !== {1'b1, 13'h0100, 16'h00F0}) begin
                    $display("FAIL slot_port: load %b addr %h din %h want 1 0100 00f0", o_vram_load, o_vram_addr, o_vram_din); n_fail++; end
            end
            tick();
        end
        i_cpu_req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (o_fill_done) got = 1'b1;
        end
        n_cmp++; if (got !== 1'b1) begin $display("FAIL slot_done: got %b want 1 within 60 cycles", got); n_fail++; end
        tick();
        bad = 0;
        for (int a = 0; a < 10; a++) if (mem[13'h0100 + 13'(a)] !== 16'h00F0) bad++;
        n_cmp++; if (bad !== 0) begin $display("FAIL slot_mem: %0d bad words want 0", bad); n_fail++; end
        n_cmp++; if (mem[13'h0200] !== 16'h1111) begin $display("FAIL slot_cpu_mem: got %h want 1111", mem[13'h0200]); n_fail++; end
    endtask

    task automatic test_zero_and_ignore();
        take_snap();
        start_fill(13'h0000, 14'd0, 16'hBEEF);
        tick();
        i_fill_start = 1'b0;
        n_cmp++; if ({o_fill_done, o_fill_busy, o_vram_load} !== 3'b100) begin
            $display("FAIL zero_len: done,busy,load %b want 100", {o_fill_done, o_fill_busy, o_vram_load}); n_fail++; end
        tick();
        n_cmp++; if ({o_fill_done, o_fill_busy, o_vram_load} !== 3'b000) begin
            $display("FAIL zero_after: done,busy,load %b want 000", {o_fill_done, o_fill_busy, o_vram_load}); n_fail++; end
        start_fill(13'h0300, 14'd3, 16'h3333);
        tick();
        start_fill(13'h0400, 14'd5, 16'h4444);
        #1;
        n_cmp++; if (o_fill_busy !== 1'b1) begin $display("FAIL ign_busy: got %b want 1", o_fill_busy); n_fail++; end
        tick();
        i_fill_start = 1'b0;
        tick(); tick();
        n_cmp++; if (o_fill_done !== 1'b1) begin $display("FAIL ign_done: got %b want 1", o_fill_done); n_fail++; end
        tick(); tick();
        n_cmp++; if ((wr_cnt[13'h0400] - snap[13'h0400]) !== 0 || mem[13'h0302] !== 16'h3333) begin
            $display("FAIL ign_mem: writes@400 %0d mem@302 %h want 0 3333", wr_cnt[13'h0400] - snap[13'h0400], mem[13'h0302]); n_fail++; end
    endtask

    task automatic test_abort();
        logic saw_done;
        take_snap();
        start_fill(13'h0500, 14'd20, 16'h5555);
        tick();
        i_fill_start = 1'b0;
        tick(); tick();
        i_fill_abort = 1'b1;
        tick();
        i_fill_abort = 1'b0;
        n_cmp++; if (o_fill_busy !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", o_fill_busy); n_fail++; end
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (o_fill_done) saw_done = 1'b1;
            tick();
        end
        n_cmp++; if (saw_done !== 1'b0) begin $display("FAIL abort_nodone: got %b want 0", saw_done); n_fail++; end
        n_cmp++; if ((wr_cnt[13'h0502] - snap[13'h0502]) !== 1 || (wr_cnt[13'h0503] - snap[13'h0503]) !== 0) begin
            $display("FAIL abort_words: writes@502 %0d @503 %0d want 1 0", wr_cnt[13'h0502] - snap[13'h0502], wr_cnt[13'h0503] - snap[13'h0503]); n_fail++; end
    endtask

    task automatic test_full_fill();
        int bad;
        take_snap();
        start_fill(13'h0000, 14'd8192, 16'hFFFF);
        tick();
        i_fill_start = 1'b0;
        bad = 0;
        for (int k = 0; k < 8192; k++) begin
            tick();
            if (o_vram_load !== 1'b1 || o_vram_addr !== 13'(k)) bad++;
        end
        n_cmp++; if (bad !== 0) begin $display("FAIL full_stream: %0d bad cycles want 0", bad); n_fail++; end
        n_cmp++; if (o_fill_done !== 1'b1) begin $display("FAIL full_done: got %b want 1", o_fill_done); n_fail++; end
        tick();
        bad = 0;
        for (int a = 0; a < 8192; a++) if ((wr_cnt[a] - snap[a]) !== 1 || mem[a] !== 16'hFFFF) bad++;
        n_cmp++; if (bad !== 0) begin $display("FAIL full_once: %0d bad words want 0", bad); n_fail++; end
    endtask

    task automatic test_reset_mid_fill();
        int extra;
        take_snap();
        start_fill(13'h0000, 14'd8192, 16'h0F0F);
        tick();
        i_fill_start = 1'b0;
        repeat (101) tick();
        n_cmp++; if ({o_vram_load, o_vram_addr} !== {1'b1, 13'd100}) begin
            $display("FAIL mid_word100: load %b addr %0d want 1 100", o_vram_load, o_vram_addr); n_fail++; end
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if ({o_vram_load, o_vram_addr, o_vram_din, o_fill_busy, o_fill_done} !== 32'd0) begin
            $display("FAIL mid_async: load %b addr %h din %h busy %b done %b want all 0", o_vram_load, o_vram_addr, o_vram_din, o_fill_busy, o_fill_done); n_fail++; end
        tick(); tick();
        i_rst_n = 1'b1;
        repeat (20) tick();
        n_cmp++; if (o_fill_busy !== 1'b0) begin $display("FAIL mid_busy: got %b want 0", o_fill_busy); n_fail++; end
        extra = 0;
        for (int a = 100; a < 8192; a++) extra += wr_cnt[a] - snap[a];
        n_cmp++; if (extra !== 0 || (wr_cnt[99] - snap[99]) !== 1) begin
            $display("FAIL mid_words: writes 100+ %0d, writes@99 %0d want 0 1", extra, wr_cnt[99] - snap[99]); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_back_to_back();
        test_fill_wrap();
        test_contention();
        test_zero_and_ignore();
        test_abort();
        test_full_fill();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
